// File: rtl/trap_controller_if.sv
// Execute-stage to trap-sequencer bundle: instruction/event inputs, interrupt
// state from the CSR file, and the trap/return/gating outputs toward the CSR file.
interface trap_controller_if #(parameter int XLEN = 32);
    logic            clk_en_i;
    logic            exs_en_i;
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [7:0]      ex_excp_i;
    logic            ex_is_store_i;
    logic            ex_mret_i;
    logic            ex_sret_i;
    logic            ex_uret_i;
    logic            ex_wfi_i;
    logic            ex_csr_wr_i;
    logic [1:0]      mode_i;
    logic            mstatus_mie_i;
    logic [2:0]      mie_i;
    logic            irq_sw_i;
    logic            irq_timer_i;
    logic            irq_ext_i;
    logic            jump_to_trap_o;
    logic [XLEN-1:0] excp_cause_o;
    logic [XLEN-1:0] excp_pc_o;
    logic            trap_rtn_o;
    logic [1:0]      trap_rtn_mode_o;
    logic            csr_wr_en_o;
    logic            stall_o;
    logic            flush_o;

    modport master (
        output clk_en_i, exs_en_i, ex_valid_i, ex_pc_i, ex_excp_i, ex_is_store_i,
               ex_mret_i, ex_sret_i, ex_uret_i, ex_wfi_i, ex_csr_wr_i, mode_i,
               mstatus_mie_i, mie_i, irq_sw_i, irq_timer_i, irq_ext_i,
        input  jump_to_trap_o, excp_cause_o, excp_pc_o, trap_rtn_o, trap_rtn_mode_o,
               csr_wr_en_o, stall_o, flush_o
    );

    modport slave (
        input  clk_en_i, exs_en_i, ex_valid_i, ex_pc_i, ex_excp_i, ex_is_store_i,
               ex_mret_i, ex_sret_i, ex_uret_i, ex_wfi_i, ex_csr_wr_i, mode_i,
               mstatus_mie_i, mie_i, irq_sw_i, irq_timer_i, irq_ext_i,
        output jump_to_trap_o, excp_cause_o, excp_pc_o, trap_rtn_o, trap_rtn_mode_o,
               csr_wr_en_o, stall_o, flush_o
    );
endinterface

// File: rtl/trap_controller.sv
// Execute-stage trap sequencer: prioritises interrupts/exceptions/returns/WFI and
// drives the one-cycle trap and return strobes, stall/flush and CSR write gating.
module trap_controller #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk_i,
    input logic               reset_i,
    trap_controller_if.slave  bus
);
    typedef enum logic [2:0] {S_RUN, S_TRAP, S_RTN, S_FLUSH, S_WFI} state_e;

    state_e          state_q, state_d;
    logic [2:0]      irq_q;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] wfi_epc_q, wfi_epc_d;
    logic [1:0]      rtn_mode_q, rtn_mode_d;
    logic [2:0]      irq_en;
    logic            irq_pend, irq_take, ex_go;

    // ext > sw > timer among the enabled pending sources
    function automatic logic [XLEN-1:0] irq_cause(input logic [2:0] pend);
        logic [XLEN-1:0] c;
        c = '0;
        c[XLEN-1] = 1'b1;
        if (pend[2])      c[3:0] = 4'd11;
        else if (pend[0]) c[3:0] = 4'd3;
        else              c[3:0] = 4'd7;
        return c;
    endfunction

    function automatic logic [XLEN-1:0] excp_cause(input logic [7:0] excp,
                                                   input logic is_store,
                                                   input logic [1:0] mode);
        logic [XLEN-1:0] c;
        c = '0;
        if (excp[1])      c[3:0] = 4'd1;
        else if (excp[0]) c[3:0] = 4'd0;
        else if (excp[2]) c[3:0] = 4'd2;
        else if (excp[3]) c[3:0] = 4'd3;
        else if (excp[4]) c[3:0] = 4'd8 + {2'b00, mode};
        else if (excp[5]) c[3:0] = 4'd4;
        else if (excp[6]) c[3:0] = 4'd6;
        else              c[3:0] = is_store ? 4'd7 : 4'd5;
        return c;
    endfunction

    assign irq_en   = irq_q & bus.mie_i;
    assign irq_pend = |irq_en;
    assign irq_take = irq_pend & ((bus.mode_i != 2'd3) | bus.mstatus_mie_i);
    assign ex_go    = bus.exs_en_i & bus.ex_valid_i;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        wfi_epc_d   = wfi_epc_q;
        rtn_mode_d  = rtn_mode_q;
        case (state_q)
            S_RUN: begin
                if (ex_go) begin
                    if (irq_take) begin
                        state_d = S_TRAP;
                        cause_d = irq_cause(irq_en);
                        epc_d   = bus.ex_pc_i;
                    end else if (|bus.ex_excp_i) begin
                        state_d = S_TRAP;
                        cause_d = excp_cause(bus.ex_excp_i, bus.ex_is_store_i, bus.mode_i);
                        epc_d   = bus.ex_pc_i;
                    end else if (bus.ex_mret_i | bus.ex_sret_i | bus.ex_uret_i) begin
                        state_d    = S_RTN;
                        rtn_mode_d = bus.ex_mret_i ? 2'd3 : (bus.ex_sret_i ? 2'd1 : 2'd0);
                    end else if (bus.ex_wfi_i) begin
                        state_d   = S_WFI;
                        wfi_epc_d = bus.ex_pc_i + XLEN'(4);
                    end
                end
            end
            S_TRAP, S_RTN: begin
                state_d     = S_FLUSH;
                flush_cnt_d = 3'(FLUSH_CYCLES - 1);
            end
            S_FLUSH: begin
                if (flush_cnt_q == 3'd0) state_d = S_RUN;
                else                     flush_cnt_d = flush_cnt_q - 3'd1;
            end
            S_WFI: begin
                // A pending-but-globally-masked interrupt wakes the core without trapping
                if (irq_take) begin
                    state_d = S_TRAP;
                    cause_d = irq_cause(irq_en);
                    epc_d   = wfi_epc_q;
                end else if (irq_pend) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_RUN;
            irq_q       <= 3'b000;
            flush_cnt_q <= 3'd0;
            cause_q     <= '0;
            epc_q       <= '0;
            wfi_epc_q   <= '0;
            rtn_mode_q  <= 2'd0;
        end else if (bus.clk_en_i) begin
            state_q     <= state_d;
            irq_q       <= {bus.irq_ext_i, bus.irq_timer_i, bus.irq_sw_i};
            flush_cnt_q <= flush_cnt_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            wfi_epc_q   <= wfi_epc_d;
            rtn_mode_q  <= rtn_mode_d;
        end
    end

    assign bus.jump_to_trap_o  = (state_q == S_TRAP);
    assign bus.trap_rtn_o      = (state_q == S_RTN);
    assign bus.flush_o         = (state_q == S_FLUSH);
    assign bus.stall_o         = (state_q != S_RUN);
    assign bus.excp_cause_o    = cause_q;
    assign bus.excp_pc_o       = epc_q;
    assign bus.trap_rtn_mode_o = rtn_mode_q;
    assign bus.csr_wr_en_o     = ex_go & bus.ex_csr_wr_i & (state_q == S_RUN)
                               & ~irq_take & ~(|bus.ex_excp_i);
endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: expected strobes are queued when
// stimulus is driven and compared when the strobe appears.
module tb_trap_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        bit          is_rtn;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [1:0]  mode;
    } exp_t;
    exp_t sb[$];

    trap_controller_if #(.XLEN(32)) bus();
    trap_controller #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.ex_valid_i = 1'b0; bus.ex_pc_i = '0; bus.ex_excp_i = '0;
        bus.ex_is_store_i = 1'b0; bus.ex_mret_i = 1'b0; bus.ex_sret_i = 1'b0;
        bus.ex_uret_i = 1'b0; bus.ex_wfi_i = 1'b0; bus.ex_csr_wr_i = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [7:0] excp,
                         input logic mret, input logic sret, input logic uret,
                         input logic wfi, input logic csr_wr);
        bus.ex_valid_i = 1'b1; bus.ex_pc_i = pc; bus.ex_excp_i = excp;
        bus.ex_mret_i = mret; bus.ex_sret_i = sret; bus.ex_uret_i = uret;
        bus.ex_wfi_i = wfi; bus.ex_csr_wr_i = csr_wr;
    endtask

    task automatic push(input bit is_rtn, input logic [31:0] cause,
                        input logic [31:0] epc, input logic [1:0] mode);
        exp_t e;
        e.is_rtn = is_rtn; e.cause = cause; e.epc = epc; e.mode = mode;
        sb.push_back(e);
    endtask

    task automatic wait_strobe(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.jump_to_trap_o || bus.trap_rtn_o) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.stall_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.clk_en_i = 1'b1; bus.exs_en_i = 1'b1; bus.mode_i = 2'd3;
        bus.mstatus_mie_i = 1'b0; bus.mie_i = 3'b000;
        bus.irq_sw_i = 1'b0; bus.irq_timer_i = 1'b0; bus.irq_ext_i = 1'b0;
        idle();
        rst = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++;
        if ({bus.jump_to_trap_o, bus.trap_rtn_o, bus.csr_wr_en_o, bus.stall_o, bus.flush_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b, required 00000",
                {bus.jump_to_trap_o, bus.trap_rtn_o, bus.csr_wr_en_o, bus.stall_o, bus.flush_o});
        end
        n_checks++;
        if ({bus.excp_cause_o, bus.excp_pc_o, bus.trap_rtn_mode_o} !== 66'b0) begin
            n_fail++; $display("FAIL reset_data: cause %h epc %h mode %0d, required all 0",
                bus.excp_cause_o, bus.excp_pc_o, bus.trap_rtn_mode_o);
        end
        rst = 1'b0;
        @(negedge clk);
        drive(32'h40, 8'h00, 0, 0, 0, 0, 1'b1);
        #1;
        n_checks++;
        if (bus.csr_wr_en_o !== 1'b1) begin
            n_fail++; $display("FAIL csr_wr_follow_1: got %b, required 1", bus.csr_wr_en_o);
        end
        bus.ex_csr_wr_i = 1'b0;
        #1;
        n_checks++;
        if (bus.csr_wr_en_o !== 1'b0) begin
            n_fail++; $display("FAIL csr_wr_follow_0: got %b, required 0", bus.csr_wr_en_o);
        end
        bus.clk_en_i = 1'b0; bus.ex_csr_wr_i = 1'b1;
        #1;
        n_checks++;
        if (bus.csr_wr_en_o !== 1'b1) begin
            n_fail++; $display("FAIL csr_wr_clk_en_low: got %b, required 1", bus.csr_wr_en_o);
        end
        bus.clk_en_i = 1'b1;
        @(negedge clk); idle();
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL no_event_stall: got %b, required 0", bus.stall_o);
        end
    endtask

    task automatic test_exception_priority();
        exp_t e; bit found;
        bus.mode_i = 2'd3;
        push(1'b0, 32'd2, 32'h100, 2'd0);
        drive(32'h100, 8'b0010_0100, 0, 0, 0, 0, 1'b1);
        #1;
        n_checks++;
        if (bus.csr_wr_en_o !== 1'b0) begin
            n_fail++; $display("FAIL excp_csr_gate: got %b, required 0", bus.csr_wr_en_o);
        end
        @(negedge clk); idle();
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL excp_strobe_timeout: got %b, required 1", found);
        end
        n_checks++;
        if ({bus.jump_to_trap_o, bus.trap_rtn_o, bus.stall_o} !== {~e.is_rtn, e.is_rtn, 1'b1}) begin
            n_fail++; $display("FAIL excp_strobe: got jump %b rtn %b stall %b, required 1 0 1",
                bus.jump_to_trap_o, bus.trap_rtn_o, bus.stall_o);
        end
        n_checks++;
        if (bus.excp_cause_o !== e.cause || bus.excp_pc_o !== e.epc) begin
            n_fail++; $display("FAIL excp_cause_epc: got %h/%h, required %h/%h",
                bus.excp_cause_o, bus.excp_pc_o, e.cause, e.epc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.jump_to_trap_o !== 1'b0 || bus.flush_o !== 1'b1) begin
            n_fail++; $display("FAIL excp_flush1: got jump %b flush %b, required 0 1",
                bus.jump_to_trap_o, bus.flush_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.flush_o !== 1'b1 || bus.excp_cause_o !== e.cause || bus.excp_pc_o !== e.epc) begin
            n_fail++; $display("FAIL excp_flush2_hold: got flush %b cause %h epc %h, required 1 %h %h",
                bus.flush_o, bus.excp_cause_o, bus.excp_pc_o, e.cause, e.epc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.flush_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL excp_flush_end: got flush %b stall %b, required 0 0",
                bus.flush_o, bus.stall_o);
        end
    endtask

    task automatic test_irq_beats_ecall();
        exp_t e; bit found, ok;
        bus.mode_i = 2'd0; bus.mstatus_mie_i = 1'b0; bus.mie_i = 3'b010;
        bus.irq_timer_i = 1'b1;
        @(negedge clk); @(negedge clk);
        push(1'b0, 32'h8000_0007, 32'h200, 2'd0);
        drive(32'h200, 8'b0001_0000, 0, 0, 0, 0, 1'b1);
        #1;
        n_checks++;
        if (bus.csr_wr_en_o !== 1'b0) begin
            n_fail++; $display("FAIL irq_csr_gate: got %b, required 0", bus.csr_wr_en_o);
        end
        @(negedge clk); idle(); bus.irq_timer_i = 1'b0;
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1 || bus.jump_to_trap_o !== 1'b1) begin
            n_fail++; $display("FAIL irq_strobe: got found %b jump %b, required 1 1", found, bus.jump_to_trap_o);
        end
        n_checks++;
        if (bus.excp_cause_o !== e.cause || bus.excp_pc_o !== e.epc) begin
            n_fail++; $display("FAIL irq_cause_epc: got %h/%h, required %h/%h",
                bus.excp_cause_o, bus.excp_pc_o, e.cause, e.epc);
        end
        wait_run(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL irq_return_run: got %b, required 1", ok);
        end
    endtask

    task automatic test_masked_irq_and_mret();
        exp_t e; bit found;
        bus.mode_i = 2'd3; bus.mstatus_mie_i = 1'b0; bus.mie_i = 3'b001; bus.irq_sw_i = 1'b1;
        @(negedge clk); @(negedge clk);
        drive(32'h2F0, 8'h00, 0, 0, 0, 0, 1'b1);
        #1;
        n_checks++;
        if (bus.csr_wr_en_o !== 1'b1) begin
            n_fail++; $display("FAIL masked_irq_csr: got %b, required 1", bus.csr_wr_en_o);
        end
        @(negedge clk); idle();
        n_checks++;
        if (bus.jump_to_trap_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL masked_irq_no_trap: got jump %b stall %b, required 0 0",
                bus.jump_to_trap_o, bus.stall_o);
        end
        push(1'b1, 32'h0, 32'h0, 2'd3);
        drive(32'h300, 8'h00, 1, 0, 0, 0, 1'b0);
        @(negedge clk); idle();
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1 || {bus.trap_rtn_o, bus.jump_to_trap_o} !== {e.is_rtn, ~e.is_rtn}) begin
            n_fail++; $display("FAIL mret_strobe: got rtn %b jump %b, required 1 0",
                bus.trap_rtn_o, bus.jump_to_trap_o);
        end
        n_checks++;
        if (bus.trap_rtn_mode_o !== e.mode) begin
            n_fail++; $display("FAIL mret_mode: got %0d, required %0d", bus.trap_rtn_mode_o, e.mode);
        end
        @(negedge clk);
        n_checks++;
        if (bus.trap_rtn_o !== 1'b0 || bus.flush_o !== 1'b1 || bus.trap_rtn_mode_o !== e.mode) begin
            n_fail++; $display("FAIL mret_flush1: got rtn %b flush %b mode %0d, required 0 1 %0d",
                bus.trap_rtn_o, bus.flush_o, bus.trap_rtn_mode_o, e.mode);
        end
        @(negedge clk);
        n_checks++;
        if (bus.flush_o !== 1'b1) begin
            n_fail++; $display("FAIL mret_flush2: got %b, required 1", bus.flush_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.flush_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL mret_flush_end: got flush %b stall %b, required 0 0",
                bus.flush_o, bus.stall_o);
        end
        bus.irq_sw_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_return_priority();
        exp_t e; bit found, ok;
        push(1'b1, 32'h0, 32'h0, 2'd1);
        drive(32'h310, 8'h00, 0, 1, 1, 0, 1'b0);
        @(negedge clk); idle();
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1 || bus.trap_rtn_o !== 1'b1 || bus.trap_rtn_mode_o !== e.mode) begin
            n_fail++; $display("FAIL sret_over_uret: got rtn %b mode %0d, required 1 %0d",
                bus.trap_rtn_o, bus.trap_rtn_mode_o, e.mode);
        end
        wait_run(ok);
    endtask

    task automatic test_wfi();
        exp_t e; bit found, ok, seen;
        bus.mode_i = 2'd3; bus.mstatus_mie_i = 1'b1; bus.mie_i = 3'b100;
        drive(32'hFFFF_FFFC, 8'h00, 0, 0, 0, 1, 1'b0);
        @(negedge clk); idle();
        n_checks++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++; $display("FAIL wfi_stall: got %b, required 1", bus.stall_o);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.stall_o !== 1'b1 || bus.jump_to_trap_o !== 1'b0) begin
            n_fail++; $display("FAIL wfi_sleep: got stall %b jump %b, required 1 0",
                bus.stall_o, bus.jump_to_trap_o);
        end
        push(1'b0, 32'h8000_000B, 32'h0000_0000, 2'd0);
        bus.irq_ext_i = 1'b1;
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1 || bus.jump_to_trap_o !== 1'b1) begin
            n_fail++; $display("FAIL wfi_wake_strobe: got found %b jump %b, required 1 1",
                found, bus.jump_to_trap_o);
        end
        n_checks++;
        if (bus.excp_cause_o !== e.cause || bus.excp_pc_o !== e.epc) begin
            n_fail++; $display("FAIL wfi_cause_epc: got %h/%h, required %h/%h",
                bus.excp_cause_o, bus.excp_pc_o, e.cause, e.epc);
        end
        bus.irq_ext_i = 1'b0;
        wait_run(ok);
        @(negedge clk);
        bus.mstatus_mie_i = 1'b0;
        drive(32'hFFFF_FFFC, 8'h00, 0, 0, 0, 1, 1'b0);
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
        bus.irq_ext_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.jump_to_trap_o) seen = 1'b1;
            if (!bus.stall_o) break;
        end
        n_checks++;
        if (bus.stall_o !== 1'b0 || seen !== 1'b0) begin
            n_fail++; $display("FAIL wfi_masked_resume: got stall %b strobe %b, required 0 0",
                bus.stall_o, seen);
        end
        n_checks++;
        if (bus.excp_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL wfi_masked_epc_hold: got %h, required 00000000", bus.excp_pc_o);
        end
        bus.irq_ext_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clk_en_and_reset();
        exp_t e; bit found;
        bus.mode_i = 2'd3; bus.mstatus_mie_i = 1'b0; bus.mie_i = 3'b000;
        push(1'b0, 32'd7, 32'h400, 2'd0);
        drive(32'h400, 8'b1000_0000, 0, 0, 0, 0, 1'b0);
        bus.ex_is_store_i = 1'b1;
        @(negedge clk); idle();
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1 || bus.excp_cause_o !== e.cause || bus.excp_pc_o !== e.epc) begin
            n_fail++; $display("FAIL store_fault: got found %b cause %h epc %h, required 1 %h %h",
                found, bus.excp_cause_o, bus.excp_pc_o, e.cause, e.epc);
        end
        @(negedge clk);
        bus.clk_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.flush_o !== 1'b1) begin
                n_fail++; $display("FAIL clk_en_hold_%0d: got flush %b, required 1", i, bus.flush_o);
            end
        end
        bus.clk_en_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.flush_o !== 1'b1) begin
            n_fail++; $display("FAIL clk_en_resume: got flush %b, required 1", bus.flush_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.flush_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL clk_en_flush_end: got flush %b stall %b, required 0 0",
                bus.flush_o, bus.stall_o);
        end
        push(1'b0, 32'd11, 32'h500, 2'd0);
        drive(32'h500, 8'b0001_0000, 0, 0, 0, 0, 1'b0);
        @(negedge clk); idle();
        wait_strobe(found);
        e = sb.pop_front();
        n_checks++;
        if (found !== 1'b1 || bus.excp_cause_o !== e.cause || bus.excp_pc_o !== e.epc) begin
            n_fail++; $display("FAIL ecall_m: got found %b cause %h epc %h, required 1 %h %h",
                found, bus.excp_cause_o, bus.excp_pc_o, e.cause, e.epc);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.stall_o, bus.flush_o, bus.jump_to_trap_o} !== 3'b000 || bus.excp_cause_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_flush: got stall %b flush %b jump %b cause %h, required 0 0 0 0",
                bus.stall_o, bus.flush_o, bus.jump_to_trap_o, bus.excp_cause_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL run_after_reset: got stall %b, required 0", bus.stall_o);
        end
    endtask

    initial begin
        test_reset();
        test_exception_priority();
        test_irq_beats_ecall();
        test_masked_irq_and_mret();
        test_return_priority();
        test_wfi();
        test_clk_en_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
